cpu_pc_gen: RTL and testbench

Program-counter generation stage that sits directly upstream of the instruction-fetch stage and drives its pc and pc_ce inputs. It holds the architectural fetch PC and advances it sequentially. It applies branch and exception/flush redirects, freezes on pipeline stall, and buffers a redirect that arrives while stalled until the stall releases.

---
 rtl/cpu_pc_gen.sv | 68 ++++++
 tb/tb_cpu_pc_gen.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_pc_gen.sv
// Program-counter generator feeding the fetch stage: sequential advance, branch/flush redirects,
// stall freeze with a one-entry redirect buffer. Optional fetch counter via CPU_PC_FETCH_COUNT_EN.
module cpu_pc_gen #(
   parameter logic [31:0] RESET_VECTOR      = 32'hBFC0_0000,
   parameter int unsigned EXCEPT_PRIO_FLUSH = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        flush,
   input  logic [31:0] flush_pc,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
`ifdef CPU_PC_FETCH_COUNT_EN
   output logic [31:0] fetch_count,
`endif
   output logic [31:0] pc,
   output logic        pc_ce
);

   localparam bit FLUSH_OVER_STALL = (EXCEPT_PRIO_FLUSH != 0);

   logic        pend_valid;
   logic [31:0] pend_pc;
   logic        flush_now;
   logic        redirect_held;

   assign flush_now     = flush && (!stall || FLUSH_OVER_STALL);
   assign redirect_held = branch_taken || flush;

   // The first edge out of reset only raises pc_ce, so RESET_VECTOR is the first address fetched.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc         <= RESET_VECTOR;
         pc_ce      <= 1'b0;
         pend_valid <= 1'b0;
         pend_pc    <= '0;
      end else if (!pc_ce) begin
         pc_ce <= 1'b1;
      end else if (flush_now) begin
         pc         <= flush_pc;
         pend_valid <= 1'b0;
      end else if (stall) begin
         if (redirect_held) begin
            pend_pc    <= flush ? flush_pc : branch_target;
            pend_valid <= 1'b1;
         end
      end else if (pend_valid) begin
         pc         <= branch_taken ? branch_target : pend_pc;
         pend_valid <= 1'b0;
      end else if (branch_taken) begin
         pc <= branch_target;
      end else begin
         pc <= pc + 32'd4;
      end
   end

`ifdef CPU_PC_FETCH_COUNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_count <= '0;
      end else if (pc_ce && !stall) begin
         fetch_count <= fetch_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_cpu_pc_gen.sv
// Self-checking bench for cpu_pc_gen: directed literal checks plus randomized traffic
// compared every cycle against a behavioural model.
module tb_cpu_pc_gen;

   localparam logic [31:0] RV = 32'hBFC0_0000;
   localparam bit PRIO = 1'b1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] flush_pc = '0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = '0;
   logic [31:0] pc;
   logic        pc_ce;
`ifdef CPU_PC_FETCH_COUNT_EN
   logic [31:0] fetch_count;
`endif

   int n_checks = 0;
   int n_fail = 0;

   // Reference model state: the pending redirect is a queue holding at most one target.
   logic [31:0] m_pc;
   logic        m_ce;
   logic [31:0] m_cnt;
   logic [31:0] pend_q[$];
   bit          model_valid = 1'b0;

   cpu_pc_gen dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flush_pc(flush_pc),
      .branch_taken(branch_taken), .branch_target(branch_target),
`ifdef CPU_PC_FETCH_COUNT_EN
      .fetch_count(fetch_count),
`endif
      .pc(pc), .pc_ce(pc_ce)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst) begin
         m_pc = RV;
         m_ce = 1'b0;
         m_cnt = '0;
         pend_q.delete();
         model_valid = 1'b1;
      end else if (model_valid) begin
         if (m_ce && !stall) m_cnt = m_cnt + 1;
         if (!m_ce) begin
            m_ce = 1'b1;
         end else if (flush && (!stall || PRIO)) begin
            m_pc = flush_pc;
            pend_q.delete();
         end else if (stall) begin
            if (flush || branch_taken) begin
               pend_q.delete();
               pend_q.push_back(flush ? flush_pc : branch_target);
            end
         end else if (pend_q.size() != 0) begin
            m_pc = branch_taken ? branch_target : pend_q[0];
            pend_q.delete();
         end else if (branch_taken) begin
            m_pc = branch_target;
         end else begin
            m_pc = m_pc + 32'd4;
         end
      end
   end

   always @(negedge clk) begin
      if (model_valid) begin
         n_checks++;
         if (pc !== m_pc || pc_ce !== m_ce) begin
            n_fail++;
            $display("[TB] FAIL model_cmp t=%0t pc=%h ce=%b expected pc=%h ce=%b", $time, pc, pc_ce, m_pc, m_ce);
         end
`ifdef CPU_PC_FETCH_COUNT_EN
         n_checks++;
         if (fetch_count !== m_cnt) begin
            n_fail++;
            $display("[TB] FAIL model_cnt t=%0t fetch_count=%0d expected %0d", $time, fetch_count, m_cnt);
         end
`endif
      end
   end

   task automatic applyStimulus(input logic r, input logic s, input logic f, input logic [31:0] fpc,
                                input logic b, input logic [31:0] bt);
      rst = r; stall = s; flush = f; flush_pc = fpc; branch_taken = b; branch_target = bt;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] exp_pc, input logic exp_ce);
      n_checks++;
      if (pc !== exp_pc || pc_ce !== exp_ce) begin
         n_fail++;
         $display("[TB] FAIL %s pc=%h ce=%b expected pc=%h ce=%b", name, pc, pc_ce, exp_pc, exp_ce);
      end
      n_checks++;
      if (m_pc !== exp_pc || m_ce !== exp_ce) begin
         n_fail++;
         $display("[TB] FAIL %s_model pc=%h ce=%b expected pc=%h ce=%b", name, m_pc, m_ce, exp_pc, exp_ce);
      end
   endtask

   task automatic idle();
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   initial begin
      // Reset release and sequential run
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("reset1", RV, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("reset2", RV, 1'b0);
`ifdef CPU_PC_FETCH_COUNT_EN
      n_checks++;
      if (fetch_count !== 32'd0) begin
         n_fail++;
         $display("[TB] FAIL count_reset fetch_count=%0d expected 0", fetch_count);
      end
`endif
      idle(); checkOutput("release", RV, 1'b1);
      idle(); checkOutput("seq1", 32'hBFC0_0004, 1'b1);
      idle(); checkOutput("seq2", 32'hBFC0_0008, 1'b1);
      idle(); checkOutput("seq3", 32'hBFC0_000C, 1'b1);
      idle(); checkOutput("seq4", 32'hBFC0_0010, 1'b1);

      // Branch at BFC0_0008
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      idle(); idle(); idle();
      checkOutput("pre_branch", 32'hBFC0_0008, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_0100);
      checkOutput("branch", 32'h8000_0100, 1'b1);
      idle(); checkOutput("branch_next", 32'h8000_0104, 1'b1);

      // Branch buffered across a 3-cycle stall
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h8000_0200);
      checkOutput("stall1", 32'h8000_0104, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("stall2", 32'h8000_0104, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("stall3", 32'h8000_0104, 1'b1);
      idle(); checkOutput("stall_release", 32'h8000_0200, 1'b1);
      idle(); checkOutput("no_dup", 32'h8000_0204, 1'b1);

      // Flush during stall discards the pending branch
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h8000_0300);
      checkOutput("pend_branch", 32'h8000_0204, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b1, 32'hBFC0_0380, 1'b0, 32'h0);
      checkOutput("flush_in_stall", 32'hBFC0_0380, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("flush_hold", 32'hBFC0_0380, 1'b1);
      idle(); checkOutput("flush_after", 32'hBFC0_0384, 1'b1);

      // Wrap at the top of the address space
      applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
      checkOutput("wrap_pre", 32'hFFFF_FFFC, 1'b1);
      idle(); checkOutput("wrap", 32'h0000_0000, 1'b1);

      // Reset while stalled with a pending redirect
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h1234_5678);
      checkOutput("pend_pre_rst", 32'h0000_0000, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h1234_5678);
      checkOutput("rst_in_stall", RV, 1'b0);
`ifdef CPU_PC_FETCH_COUNT_EN
      n_checks++;
      if (fetch_count !== 32'd0) begin
         n_fail++;
         $display("[TB] FAIL count_rst_stall fetch_count=%0d expected 0", fetch_count);
      end
`endif
      idle(); checkOutput("rst_release2", RV, 1'b1);
      idle(); checkOutput("pend_cleared", 32'hBFC0_0004, 1'b1);

      // Randomized traffic, checked every cycle by the model
      for (int i = 0; i < 600; i++) begin
         applyStimulus(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 35),
                       ($urandom_range(0, 99) < 10), $urandom,
                       ($urandom_range(0, 99) < 25), $urandom);
      end
      idle(); idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
